// File: rtl/mips_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_decode_stage_if
//  Description : Handshake bundle between fetch, the decode stage and the
//                execute stage.
//                  fetch side   : in_valid / in_ready / in_pc / in_inst / flush
//                  execute side : out_valid / out_ready plus the decoded head
//                                 entry (pc, raw word, format, register indices,
//                                 destination, write enable, immediate, jump
//                                 target, illegal flag)
//                slave  : view used by the decode stage
//                master : view used by whoever drives fetch and consumes
//                         execute (surrounding pipeline or bench)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  out_fmt;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic [31:0] out_imm;
    logic [31:0] out_jtarget;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_fmt, out_rs, out_rt,
               out_dest, out_reg_write, out_imm, out_jtarget, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_fmt, out_rs, out_rt,
               out_dest, out_reg_write, out_imm, out_jtarget, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/mips_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mips_decode_stage
//  Description : MIPS instruction decode stage. Each accepted instruction word
//                is decoded combinationally at the input and the decoded entry
//                is pushed into a small circular FIFO; the FIFO head drives the
//                execute-side outputs directly from storage.
//  Ports       : clock - rising-edge clock
//                reset - asynchronous active-high reset
//                bus   - mips_decode_stage_if.slave (fetch in, execute out)
//  Parameters  : BUF_DEPTH - FIFO slots, power of two and at least 2
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_decode_stage #(
    parameter int BUF_DEPTH = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    mips_decode_stage_if.slave bus
);

    localparam int c_ptr_w = $clog2(BUF_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(BUF_DEPTH);

    localparam logic [1:0] c_fmt_r   = 2'd0;
    localparam logic [1:0] c_fmt_i   = 2'd1;
    localparam logic [1:0] c_fmt_j   = 2'd2;
    localparam logic [1:0] c_fmt_ill = 2'd3;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_sltiu = 6'h0B;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_fn_jr    = 6'h08;

    // r/i/j views of one instruction word
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } itype_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] address;
    } jtype_t;

    typedef union packed {
        rtype_t r;
        itype_t i;
        jtype_t j;
    } mipsinst_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fmt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        reg_write;
        logic [31:0] imm;
        logic [31:0] jtarget;
        logic        illegal;
    } entry_t;

    mipsinst_t          w_inst;
    entry_t             w_dec;
    logic [31:0]        w_sext;
    logic [31:0]        w_zext;
    logic [3:0]         w_jt_hi;
    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;

    entry_t             r_mem [BUF_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    assign w_inst = bus.in_inst;
    assign w_sext = {{16{w_inst.i.imm[15]}}, w_inst.i.imm};
    assign w_zext = {16'h0000, w_inst.i.imm};
    // Region bits come from pc+4, so a pc at the top of a 256 MB region
    // jumps into the next region (and 0xFFFFFFFC wraps to region 0).
    assign w_jt_hi = 4'((bus.in_pc + 32'd4) >> 28);

    // ------------------------------------------------------------------
    // Input-side decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = bus.in_pc;
        w_dec.inst    = bus.in_inst;
        w_dec.rs      = w_inst.r.rs;
        w_dec.rt      = w_inst.r.rt;
        w_dec.jtarget = {w_jt_hi, w_inst.j.address, 2'b00};
        case (w_inst.r.opcode)
            c_op_rtype: begin
                w_dec.fmt       = c_fmt_r;
                w_dec.dest      = w_inst.r.rd;
                w_dec.reg_write = (w_inst.r.funct != c_fn_jr);
            end
            c_op_j: begin
                w_dec.fmt = c_fmt_j;
            end
            c_op_jal: begin
                w_dec.fmt       = c_fmt_j;
                w_dec.dest      = 5'd31;
                w_dec.reg_write = 1'b1;
            end
            c_op_beq, c_op_bne, c_op_sw: begin
                w_dec.fmt = c_fmt_i;
                w_dec.imm = w_sext;
            end
            c_op_addi, c_op_addiu, c_op_slti, c_op_sltiu, c_op_lw: begin
                w_dec.fmt       = c_fmt_i;
                w_dec.dest      = w_inst.i.rt;
                w_dec.reg_write = 1'b1;
                w_dec.imm       = w_sext;
            end
            c_op_andi, c_op_ori, c_op_xori: begin
                w_dec.fmt       = c_fmt_i;
                w_dec.dest      = w_inst.i.rt;
                w_dec.reg_write = 1'b1;
                w_dec.imm       = w_zext;
            end
            c_op_lui: begin
                w_dec.fmt       = c_fmt_i;
                w_dec.dest      = w_inst.i.rt;
                w_dec.reg_write = 1'b1;
                w_dec.imm       = {w_inst.i.imm, 16'h0000};
            end
            default: begin
                w_dec.fmt     = c_fmt_ill;
                w_dec.illegal = 1'b1;
            end
        endcase
        // $zero is never a real write-back target
        if (w_dec.dest == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. Ready depends only on the stored count (plus the
    // flush/reset inputs), never on out_ready, so a full buffer refuses
    // input even on a cycle where the head is being consumed.
    // ------------------------------------------------------------------
    assign w_in_ready = !reset && (r_count < c_depth) && !bus.flush;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = bus.out_ready && (r_count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_dec;
                r_tail        <= r_tail + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = (r_count != '0);
    assign bus.out_pc        = r_mem[r_head].pc;
    assign bus.out_inst      = r_mem[r_head].inst;
    assign bus.out_fmt       = r_mem[r_head].fmt;
    assign bus.out_rs        = r_mem[r_head].rs;
    assign bus.out_rt        = r_mem[r_head].rt;
    assign bus.out_dest      = r_mem[r_head].dest;
    assign bus.out_reg_write = r_mem[r_head].reg_write;
    assign bus.out_imm       = r_mem[r_head].imm;
    assign bus.out_jtarget   = r_mem[r_head].jtarget;
    assign bus.out_illegal   = r_mem[r_head].illegal;

endmodule
`default_nettype wire

// File: tb/tb_mips_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_decode_stage
//  Description : Self-checking bench for mips_decode_stage: directed steps
//                followed by randomized traffic, all compared against a
//                queue-based reference model of the decode rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_decode_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fmt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        rw;
        logic [31:0] imm;
        logic [31:0] jt;
        logic        ill;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    exp_t q[$];

    mips_decode_stage_if bus ();

    mips_decode_stage #(.BUF_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference decode, straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
        exp_t        e;
        int unsigned op;
        int unsigned imm16;
        logic [31:0] pc4;
        op     = inst >> 26;
        imm16  = inst & 32'hFFFF;
        pc4    = pc + 32'd4;
        e.pc   = pc;
        e.inst = inst;
        e.rs   = 5'((inst >> 21) & 31);
        e.rt   = 5'((inst >> 16) & 31);
        e.jt   = (pc4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
        e.dest = 5'd0;
        e.rw   = 1'b0;
        e.imm  = 32'd0;
        e.ill  = 1'b0;
        e.fmt  = 2'd1;
        if (op == 0) begin
            e.fmt  = 2'd0;
            e.dest = 5'((inst >> 11) & 31);
            e.rw   = ((inst & 63) != 8);
        end else if (op == 2 || op == 3) begin
            e.fmt  = 2'd2;
            e.dest = (op == 3) ? 5'd31 : 5'd0;
            e.rw   = (op == 3);
        end else if (op == 4 || op == 5 || op == 'h2B) begin
            e.imm = (imm16 >= 32768) ? imm16 - 65536 : imm16;
        end else if ((op >= 8 && op <= 'h0F) || op == 'h23) begin
            e.dest = e.rt;
            e.rw   = 1'b1;
            if (op >= 'h0C && op <= 'h0E)
                e.imm = imm16;
            else if (op == 'h0F)
                e.imm = imm16 * 65536;
            else
                e.imm = (imm16 >= 32768) ? imm16 - 65536 : imm16;
        end else begin
            e.fmt = 2'd3;
            e.ill = 1'b1;
        end
        if (e.dest == 0) e.rw = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic fl);
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) && !fl));
        if (q.size() != 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_inst", bus.out_inst, q[0].inst);
            chk("out_fmt", 32'(bus.out_fmt), 32'(q[0].fmt));
            chk("out_rs", 32'(bus.out_rs), 32'(q[0].rs));
            chk("out_rt", 32'(bus.out_rt), 32'(q[0].rt));
            chk("out_dest", 32'(bus.out_dest), 32'(q[0].dest));
            chk("out_reg_write", 32'(bus.out_reg_write), 32'(q[0].rw));
            chk("out_imm", bus.out_imm, q[0].imm);
            chk("out_jtarget", bus.out_jtarget, q[0].jt);
            chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
        end
    endtask

    task automatic check_zero(input logic exp_in_ready);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_fmt", 32'(bus.out_fmt), 32'd0);
        chk("rst_out_rs", 32'(bus.out_rs), 32'd0);
        chk("rst_out_rt", 32'(bus.out_rt), 32'd0);
        chk("rst_out_dest", 32'(bus.out_dest), 32'd0);
        chk("rst_out_reg_write", 32'(bus.out_reg_write), 32'd0);
        chk("rst_out_imm", bus.out_imm, 32'd0);
        chk("rst_out_jtarget", bus.out_jtarget, 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    endtask

    // Constant expectations for the hand-written instruction cases
    task automatic expect_head(input string tag, input int fmt, input int rs, input int dest,
                               input int rw, input logic [31:0] imm);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_fmt"}, 32'(bus.out_fmt), 32'(fmt));
        chk({tag, "_rs"}, 32'(bus.out_rs), 32'(rs));
        chk({tag, "_dest"}, 32'(bus.out_dest), 32'(dest));
        chk({tag, "_rw"}, 32'(bus.out_reg_write), 32'(rw));
        chk({tag, "_imm"}, bus.out_imm, imm);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
        int n;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clock);
        if (fl) begin
            q.delete();
        end else begin
            n = q.size();
            if (ordy && n > 0) void'(q.pop_front());
            if (v && n < DEPTH) q.push_back(ref_decode(pc, inst));
        end
        #1;
        check_all(fl);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0]  ops [16];
        logic [31:0] r;
        logic [31:0] body;
        logic [5:0]  op;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
        r    = $urandom();
        body = $urandom();
        if ($urandom_range(0, 4) == 0) op = r[5:0];
        else op = ops[$urandom_range(0, 15)];
        if (op == 6'h00 && $urandom_range(0, 5) == 0) body = (body & ~32'h3F) | 32'h08;
        if ($urandom_range(0, 7) == 0) body = body & ~32'h001F_F800;
        return {op, body[25:0]};
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] hold_pc;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_inst   = 32'd0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_zero(1'b0);
        reset = 1'b0;
        #1;
        check_zero(1'b1);

        // Decode of individual instruction classes, one per cycle
        step(1, 32'h0040_0000, 32'h0022_1820, 1, 0);
        expect_head("add", 0, 1, 3, 1, 32'h0);
        chk("add_rt", 32'(bus.out_rt), 32'd2);
        step(1, 32'h0040_0004, 32'h2509_FFFC, 1, 0);
        expect_head("addiu", 1, 8, 9, 1, 32'hFFFF_FFFC);
        step(1, 32'h0040_0008, 32'h3421_F000, 1, 0);
        expect_head("ori", 1, 1, 1, 1, 32'h0000_F000);
        step(1, 32'h0040_000C, 32'h3C01_1234, 1, 0);
        expect_head("lui", 1, 0, 1, 1, 32'h1234_0000);
        step(1, 32'h0040_0000, 32'h0C10_0000, 1, 0);
        expect_head("jal", 2, 0, 31, 1, 32'h0);
        chk("jal_jtarget", bus.out_jtarget, 32'h0040_0000);
        step(1, 32'h0040_0010, 32'hAC22_0000, 1, 0);
        chk("sw_reg_write", 32'(bus.out_reg_write), 32'd0);
        step(1, 32'h0040_0014, 32'hFC00_0000, 1, 0);
        chk("ill_fmt", 32'(bus.out_fmt), 32'd3);
        chk("ill_flag", 32'(bus.out_illegal), 32'd1);
        step(1, 32'hEFFF_FFFC, 32'h0800_0001, 1, 0);
        chk("j_region_jtarget", bus.out_jtarget, 32'hF000_0004);
        step(0, 32'h0, 32'h0, 1, 0);

        // Backpressure: two accepted, third held off, then in-order drain
        step(1, 32'h0000_1000, 32'h2001_0001, 0, 0);
        step(1, 32'h0000_1004, 32'h2002_0002, 0, 0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        hold_pc = bus.out_pc;
        step(1, 32'h0000_1008, 32'h2003_0003, 0, 0);
        chk("hold_head_pc", bus.out_pc, 32'h0000_1000);
        step(1, 32'h0000_1008, 32'h2003_0003, 1, 0);
        chk("drain1_pc", bus.out_pc, 32'h0000_1004);
        step(1, 32'h0000_1008, 32'h2003_0003, 1, 0);
        chk("drain2_pc", bus.out_pc, 32'h0000_1008);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("drained", 32'(bus.out_valid), 32'd0);

        // Flush with a full buffer and a simultaneous input
        step(1, 32'h0000_2000, 32'h2004_0004, 0, 0);
        step(1, 32'h0000_2004, 32'h2005_0005, 0, 0);
        step(1, 32'h0000_2008, 32'h2006_0006, 1, 1);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset mid-cycle with one entry buffered
        step(1, 32'h0000_3000, 32'h2007_0007, 0, 0);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_zero(1'b0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_zero(1'b1);
        step(1, 32'h0000_4000, 32'h0022_1820, 1, 0);
        expect_head("post_rst", 0, 1, 3, 1, 32'h0);

        // Randomized traffic
        pc = 32'h0040_0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            else pc = $urandom() & 32'hFFFF_FFFC;
            step(1'($urandom_range(0, 3) != 0), pc, rand_inst(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch; accepts raw 32-bit MIPS instruction words interpreted through the team's mips::mipsinst union (r/i/j views).
- Decodes each word into register indices, destination, extended immediate, jump target and control flags.
- Holds the results in a small valid/ready output buffer feeding the execute stage, so that fetch-side ready is driven from registered state only.

Parameters:
- BUF_DEPTH, 2, number of decoded-entry buffer slots; power of two, >= 2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; = (count < BUF_DEPTH) && !flush.
- in_pc  in  32  address of the instruction.
- in_inst  in  32  instruction word, type mips::mipsinst.
- flush  in  1  synchronous discard of all buffered entries (branch redirect).
- out_valid  out  1  head entry valid; = (count != 0).
- out_ready  in  1  execute consumes head.
- out_pc  out  32  head pc.
- out_inst  out  32  head raw word (mips::mipsinst).
- out_fmt  out  2  0=R, 1=I, 2=J, 3=illegal.
- out_rs  out  5  source register 1.
- out_rt  out  5  source register 2.
- out_dest  out  5  write-back register.
- out_reg_write  out  1  write-back enable.
- out_imm  out  32  extended immediate.
- out_jtarget  out  32  jump target.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Decode is combinational on in_inst at the input side. Decoded fields are written into the buffer on accept (in_valid && in_ready); nothing is decoded at the output.
- Supported opcodes:
  - 0x00 R-type.
  - 0x02 j, 0x03 jal.
  - 0x04 beq, 0x05 bne.
  - 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu.
  - 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui.
  - 0x23 lw, 0x2B sw.
  - Any other opcode: fmt=3, illegal=1, reg_write=0, imm=0, dest=0.
- rs/rt: always the instruction's [25:21]/[20:16] fields, even for J-type.
- Destination:
  - R-type: rd. jr (func 0x08) sets reg_write=0.
  - I-type ALU ops and lw: rt.
  - jal: 31.
  - beq, bne, sw, j: reg_write=0.
  - reg_write is forced 0 whenever dest==0.
- Immediate:
  - Sign-extended imm[15:0] by default.
  - Zero-extended for andi/ori/xori.
  - lui: imm<<16.
  - R and J types: 0.
- Jump target: {(pc+4)[31:28], address, 2'b00}, computed for every instruction (pc+4 wraps modulo 2^32).
- Latency: accept at edge N -> out_valid high after edge N when the buffer was empty. Throughput is 1 per cycle while out_ready stays high.
- Buffer is a circular FIFO: head pointer, tail pointer, count (width clog2(BUF_DEPTH)+1).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap at BUF_DEPTH.
  - Pop when out_valid is low is a no-op.
- Full: in_ready=0; the input is not captured even if out_ready pops that cycle (no combinational ready path).
- flush: next edge sets count=0 and head=tail=0. in_ready=0 during the flush cycle, so any input that cycle is dropped. A simultaneous pop is irrelevant.
- Head outputs are driven from buffer storage and hold stable while out_valid && !out_ready.
- reset (asynchronous, any time, including mid-stream):
  - count, pointers and all storage cleared.
  - All outputs 0, except in_ready, which is 1 once reset deasserts.

Test Plan:
- Reset, then push 0x00221820 (add $3,$1,$2) at pc 0x00400000 with out_ready=1 -> next cycle: out_valid=1, fmt=0, rs=1, rt=2, dest=3, reg_write=1, imm=0.
- Push 0x2509FFFC (addiu $9,$8,-4) -> fmt=1, rs=8, dest=9, imm=0xFFFFFFFC, reg_write=1. Push 0x3421F000 (ori) -> imm=0x0000F000. Push 0x3C011234 (lui) -> imm=0x12340000.
- Push 0x0C100000 (jal) at pc 0x00400000 -> fmt=2, dest=31, reg_write=1, jtarget=0x00400000. Push 0xAC220000 (sw) -> reg_write=0. Push 0xFC000000 -> fmt=3, illegal=1.
- Hold out_ready=0 and push 3 words -> in_ready drops after 2 accepts, third word is held off, head outputs stay constant. Raise out_ready -> all 3 words drain in order, one per cycle.
- Fill the buffer to 2 entries, assert flush together with in_valid -> next cycle out_valid=0, count=0, the flush-cycle input is absent from the output.
- Assert reset asynchronously mid-stream with 1 entry buffered -> out_valid and all outputs 0 immediately; after release in_ready=1 and the next push decodes normally.
